cam_capture_ctrl: RTL

- Sequences OV7670 pixel capture into the M9K frame buffer: frames VSYNC/HREF, pairs RGB565 bytes into RGB332, generates write address/enable, and reports frame status.
- Runs entirely in the camera PCLK domain and drives the write port of the dual-port frame RAM.
- Supports single-shot (arm, capture one frame, stop) and continuous capture, so the image processor can freeze a frame.

---
 rtl/cam_capture_ctrl_pkg.sv | 25 ++
 rtl/cam_byte_packer.sv | 44 ++++
 rtl/cam_capture_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cam_capture_ctrl_pkg.sv
// Shared definitions for the OV7670 capture controller.
// Holds the controller state encoding, the default frame geometry and the
// RGB565 -> RGB332 bit positions used by the byte packer.
package cam_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 176;
    localparam int DEF_HEIGHT = 144;
    localparam int DEF_ADDR_W = 15;

    // RGB565 arrives as two bytes: RRRRRGGG then GGGBBBBB.
    // RGB332 keeps R[4:2] and G[5:3] from the first byte, B[4:3] from the second.
    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 2;
    localparam int G_LO = 0;
    localparam int B_HI = 4;
    localparam int B_LO = 3;

endpackage

// File: rtl/cam_byte_packer.sv
// Pairs camera bytes into RGB332 pixels.
// Ports:
//   clk, rst_n  - PCLK and asynchronous active-low reset
//   byte_en     - a camera byte is present on d this cycle
//   clear       - line end / capture start: drop any half pixel, back to phase 0
//   d           - camera data byte
//   phase       - 1 while holding the first byte of a pixel
//   pix_valid   - combinational: the second byte is on d now
//   pix_data    - combinational: packed RGB332 pixel, meaningful with pix_valid
module cam_byte_packer
    import cam_capture_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_en,
    input  logic       clear,
    input  logic [7:0] d,
    output logic       phase,
    output logic       pix_valid,
    output logic [7:0] pix_data
);

    logic [5:0] pix_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 1'b0;
            pix_hi <= 6'd0;
        end else if (clear) begin
            phase <= 1'b0;
        end else if (byte_en) begin
            if (!phase) begin
                pix_hi <= {d[R_HI:R_LO], d[G_HI:G_LO]};
                phase  <= 1'b1;
            end else begin
                phase <= 1'b0;
            end
        end
    end

    assign pix_valid = byte_en & phase;
    assign pix_data  = {pix_hi, d[B_HI:B_LO]};

endmodule

// File: rtl/cam_capture_ctrl.sv
// OV7670 capture sequencer feeding the write port of the frame RAM.
// Frames VSYNC/HREF, packs RGB565 byte pairs to RGB332, generates the
// write address/strobe and reports frame status. Single PCLK domain.
// Ports:
//   CLK, RESET_N       - PCLK, asynchronous active-low reset
//   VSYNC, HREF, D     - camera sync and data
//   START              - one-cycle arm request (honoured only in IDLE)
//   CONTINUOUS         - re-arm after every frame while high
//   W_ADDR/W_DATA/W_EN - registered frame RAM write port
//   BUSY               - high in ARMED or CAPTURE
//   FRAME_DONE         - one-cycle pulse at the end of a captured frame
//   LINE_ERR           - sticky malformed-line flag, cleared by an accepted START
module cam_capture_ctrl
    import cam_capture_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        D,
    input  logic              START,
    input  logic              CONTINUOUS,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              BUSY,
    output logic              FRAME_DONE,
    output logic              LINE_ERR
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0]     X_MAX     = XW'(WIDTH);
    localparam logic [YW-1:0]     Y_MAX     = YW'(HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

    state_t state;
    state_t state_next;

    logic              vsync_q;
    logic              href_q;
    logic [XW-1:0]     x;
    logic              x_over;     // a pixel arrived after the line was already full
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] line_base;  // y*WIDTH kept as a running sum

    logic vs_rise;
    logic vs_fall;
    logic href_fall;
    logic capturing;
    logic byte_en;
    logic line_end;
    logic frame_end;
    logic enter_capture;
    logic phase;
    logic pix_valid;
    logic [7:0] pix_data;

    assign vs_rise   = VSYNC & ~vsync_q;
    assign vs_fall   = ~VSYNC & vsync_q;
    assign href_fall = ~HREF & href_q;

    assign capturing     = (state == CAPTURE);
    assign byte_en       = capturing & HREF & ~VSYNC;
    // VSYNC rising while HREF is still high closes the line as well as the frame.
    assign line_end      = capturing & (href_fall | (vs_rise & HREF));
    assign frame_end     = capturing & vs_rise;
    assign enter_capture = (state == ARMED) & vs_fall;

    cam_byte_packer u_packer (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .byte_en   (byte_en),
        .clear     (line_end | enter_capture),
        .d         (D),
        .phase     (phase),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (START)   state_next = ARMED;
            ARMED:   if (vs_fall) state_next = CAPTURE;
            CAPTURE: if (vs_rise) state_next = CONTINUOUS ? ARMED : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            x          <= '0;
            x_over     <= 1'b0;
            y          <= '0;
            line_base  <= '0;
            W_ADDR     <= '0;
            W_DATA     <= 8'd0;
            W_EN       <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            LINE_ERR   <= 1'b0;
        end else begin
            vsync_q    <= VSYNC;
            href_q     <= HREF;
            BUSY       <= (state_next != IDLE);
            FRAME_DONE <= frame_end;
            W_EN       <= 1'b0;

            if (enter_capture) begin
                x         <= '0;
                x_over    <= 1'b0;
                y         <= '0;
                line_base <= '0;
            end else if (line_end) begin
                x      <= '0;
                x_over <= 1'b0;
                if (y < Y_MAX) begin
                    y         <= y + 1'b1;
                    line_base <= line_base + LINE_STEP;
                end
            end else if (pix_valid) begin
                W_DATA <= pix_data;
                W_ADDR <= line_base + ADDR_W'(x);
                W_EN   <= (x < X_MAX) && (y < Y_MAX);
                if (x < X_MAX) begin
                    x <= x + 1'b1;
                end else begin
                    x_over <= 1'b1;
                end
            end

            if ((state == IDLE) && START) begin
                LINE_ERR <= 1'b0;
            end else if (line_end && (phase || (x != X_MAX) || x_over)) begin
                LINE_ERR <= 1'b1;
            end
        end
    end

endmodule
